// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline constants: stall-controller state encoding, default
// memory-wait timeout and the load-use hazard rule.
package pipe_stall_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int STALL_CNT_W     = 16;

    // A load into $0 never creates a dependency since $0 is hard-wired to zero.
    function automatic logic load_use(
        input logic       ex_memrd,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return ex_memrd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous reset, synchronous clear and
// count enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;
    assign cnt_o    = r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_at_max) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, data-memory wait stalls,
// branch flushes, a saturating stall-cycle counter and a sticky wait timeout.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        EX_MemRd_i,
    input  logic [4:0]  EX_rt_i,
    input  logic [4:0]  ID_rs_i,
    input  logic [4:0]  ID_rt_i,
    input  logic        branch_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        PC_Enable_o,
    output logic        IF_ID_Enable_o,
    output logic        ID_EX_Enable_o,
    output logic        EX_MEM_Enable_o,
    output logic        MEM_WB_Enable_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Flush_o,
    output logic [15:0] stall_cnt_o,
    output logic        timeout_o,
    output logic        dbg_state_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_timeout;
    logic                w_lu;
    logic                w_ms;
    logic                w_wait_clr;
    logic                w_wait_en;
    logic [WAIT_W-1:0]   w_wait_cnt;
    logic [15:0]         w_stall_cnt;

    assign w_lu = load_use(EX_MemRd_i, EX_rt_i, ID_rs_i, ID_rt_i);
    // While waiting only the ack matters; a new request cannot be accepted.
    assign w_ms = ((r_state == RUN) && mem_req_i && !mem_ack_i) ||
                  ((r_state == MEM_WAIT) && !mem_ack_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_clr  = 1'b0;
        w_wait_en   = 1'b0;
        case (r_state)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_clr  = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_wait_en = 1'b1;
                if (mem_ack_i) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        PC_Enable_o     = 1'b1;
        IF_ID_Enable_o  = 1'b1;
        ID_EX_Enable_o  = 1'b1;
        EX_MEM_Enable_o = 1'b1;
        MEM_WB_Enable_o = 1'b1;
        IF_ID_Flush_o   = branch_i;
        ID_EX_Flush_o   = 1'b0;
        if (rst_i) begin
            PC_Enable_o     = 1'b0;
            IF_ID_Enable_o  = 1'b0;
            ID_EX_Enable_o  = 1'b0;
            EX_MEM_Enable_o = 1'b0;
            MEM_WB_Enable_o = 1'b0;
            IF_ID_Flush_o   = 1'b1;
            ID_EX_Flush_o   = 1'b1;
        end else if (w_ms) begin
            PC_Enable_o     = 1'b0;
            IF_ID_Enable_o  = 1'b0;
            ID_EX_Enable_o  = 1'b0;
            EX_MEM_Enable_o = 1'b0;
            MEM_WB_Enable_o = 1'b0;
            IF_ID_Flush_o   = 1'b0;
        end else if (w_lu) begin
            // Branch is held in IF/ID and re-resolved once the load data arrives.
            PC_Enable_o    = 1'b0;
            IF_ID_Enable_o = 1'b0;
            IF_ID_Flush_o  = 1'b0;
            ID_EX_Flush_o  = 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_wait_clr),
        .en_i  (w_wait_en),
        .cnt_o (w_wait_cnt)
    );

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .en_i  (!PC_Enable_o),
        .cnt_o (w_stall_cnt)
    );

    // Set on the edge that completes the TIMEOUT-th waiting cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if ((r_state == MEM_WAIT) && (w_wait_cnt == WAIT_LAST)) begin
            r_timeout <= 1'b1;
        end
    end

    assign stall_cnt_o = w_stall_cnt;
    assign timeout_o   = r_timeout;
    assign dbg_state_o = r_state;

endmodule
